anfsqrt_mag: RTL and testbench

Vector-magnitude front end for the clocked square-root unit. It accepts 16-bit unsigned (x, y) pairs and buffers them in a small FIFO. It forms the saturated 32-bit sum of squares, issues it as a query to the sqrt unit, and returns the 16-bit truncated magnitude on a valid/ready output. It sits directly upstream of the sqrt unit and owns its query/result handshake; one query is in flight at a time.

---
 rtl/anfsqrt_mag.sv | 160 ++++++++++++++++
 tb/tb_anfsqrt_mag.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/anfsqrt_mag.sv
// rtl/anfsqrt_mag.sv - (x,y) magnitude front end: sum-of-squares FIFO feeding a clocked sqrt unit
// Optional out_sat port and per-entry saturation bit under ANFSQRT_MAG_SAT_FLAG_EN.
`timescale 1ns/1ps
module anfsqrt_mag #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] sq_query,
  output logic        sq_query_valid,
  input  logic        sq_query_ready,
  input  logic [15:0] sq_result,
  input  logic        sq_result_valid,
  output logic [15:0] out_mag,
  output logic        out_valid,
  input  logic        out_ready
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
  ,
  output logic        out_sat
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
  localparam int W = 33;
`else
  localparam int W = 32;
`endif

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          init_q;
  logic [31:0]   xx, yy, sum_clip;
  logic [32:0]   sum;
  logic [W-1:0]  entry, head;
  logic          full, empty, push, pop;

  logic [1:0]    state_q, state_d;
  logic [31:0]   sq_query_q, sq_query_d;
  logic          sq_query_valid_q, sq_query_valid_d;
  logic [15:0]   out_mag_q, out_mag_d;
  logic          out_valid_q, out_valid_d;
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
  logic          issued_sat_q, issued_sat_d;
  logic          out_sat_q, out_sat_d;
`endif

  assign xx       = 32'(in_x) * 32'(in_x);
  assign yy       = 32'(in_y) * 32'(in_y);
  assign sum      = {1'b0, xx} + {1'b0, yy};
  assign sum_clip = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
  assign entry    = {sum[32], sum_clip};
`else
  assign entry    = sum_clip;
`endif

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // init_q keeps in_ready low until the first edge after reset release
  assign in_ready = init_q && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_comb begin
    state_d          = state_q;
    sq_query_d       = sq_query_q;
    sq_query_valid_d = 1'b0;
    out_mag_d        = out_mag_q;
    out_valid_d      = out_valid_q;
    pop              = 1'b0;
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
    issued_sat_d     = issued_sat_q;
    out_sat_d        = out_sat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty && sq_query_ready) begin
          sq_query_d       = head[31:0];
          sq_query_valid_d = 1'b1;
          pop              = 1'b1;
          state_d          = ST_WAIT;
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
          issued_sat_d     = head[32];
`endif
        end
      end
      ST_WAIT: begin
        if (sq_result_valid) begin
          out_mag_d   = sq_result;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
          out_sat_d   = issued_sat_q;
`endif
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q           <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      state_q          <= ST_IDLE;
      sq_query_q       <= '0;
      sq_query_valid_q <= 1'b0;
      out_mag_q        <= '0;
      out_valid_q      <= 1'b0;
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
      issued_sat_q     <= 1'b0;
      out_sat_q        <= 1'b0;
`endif
    end else begin
      init_q           <= 1'b1;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      state_q          <= state_d;
      sq_query_q       <= sq_query_d;
      sq_query_valid_q <= sq_query_valid_d;
      out_mag_q        <= out_mag_d;
      out_valid_q      <= out_valid_d;
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
      issued_sat_q     <= issued_sat_d;
      out_sat_q        <= out_sat_d;
`endif
    end
  end

  assign sq_query       = sq_query_q;
  assign sq_query_valid = sq_query_valid_q;
  assign out_mag        = out_mag_q;
  assign out_valid      = out_valid_q;
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
  assign out_sat        = out_sat_q;
`endif

endmodule

// File: tb/tb_anfsqrt_mag.sv
// tb/tb_anfsqrt_mag.sv - directed self-checking bench for anfsqrt_mag with a behavioural sqrt unit
`timescale 1ns/1ps
module tb_anfsqrt_mag;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_x, in_y;
  logic        in_valid, in_ready;
  logic [31:0] sq_query;
  logic        sq_query_valid, sq_query_ready;
  logic [15:0] sq_result;
  logic        sq_result_valid;
  logic [15:0] out_mag;
  logic        out_valid, out_ready;
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
  logic        out_sat;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic        hold_ready, stray_req, stray_done, busy;
  int          lat, cnt;
  logic [31:0] q_seen, last_q;
  int          pulse_cnt, dbl_pulse;
  logic        prev_qv;

  anfsqrt_mag #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_x(in_x), .in_y(in_y),
    .in_valid(in_valid), .in_ready(in_ready),
    .sq_query(sq_query), .sq_query_valid(sq_query_valid), .sq_query_ready(sq_query_ready),
    .sq_result(sq_result), .sq_result_valid(sq_result_valid),
    .out_mag(out_mag), .out_valid(out_valid), .out_ready(out_ready)
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
    , .out_sat(out_sat)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [15:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (32'(t) * 32'(t) <= v) r = t;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural sqrt unit: latches a query, answers after lat cycles, optional stray result.
  initial begin
    busy = 1'b0; cnt = 0; q_seen = '0; stray_done = 1'b0;
    sq_result = '0; sq_result_valid = 1'b0; sq_query_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy = 1'b0; sq_result_valid = 1'b0;
      end else if (sq_result_valid) begin
        sq_result_valid = 1'b0; busy = 1'b0;
      end else if (stray_req && !stray_done) begin
        sq_result = 16'h1234; sq_result_valid = 1'b1; stray_done = 1'b1;
      end else if (busy) begin
        if (cnt == 0) begin
          sq_result = isqrt(q_seen); sq_result_valid = 1'b1;
        end else cnt--;
      end else if (sq_query_valid) begin
        busy = 1'b1; q_seen = sq_query; cnt = lat;
      end
      sq_query_ready = reset_n && !hold_ready && !busy;
    end
  end

  initial begin
    pulse_cnt = 0; dbl_pulse = 0; prev_qv = 1'b0; last_q = '0;
    forever begin
      @(negedge clk);
      if (sq_query_valid) begin
        pulse_cnt++;
        last_q = sq_query;
        if (prev_qv) dbl_pulse++;
      end
      prev_qv = sq_query_valid;
    end
  end

  task automatic push(input logic [15:0] x, input logic [15:0] y);
    int t;
    in_x = x; in_y = y; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("push_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [15:0] exp_mag,
                          input logic [31:0] exp_q, input logic exp_sat);
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_mag"}, {16'd0, out_mag}, {16'd0, exp_mag});
    check({tag, "_query"}, last_q, exp_q);
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
`else
    if (exp_sat) t = t + 0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_cleared"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] fill_mag [5];
    logic [31:0] fill_q   [5];
    int pc, t;
    logic seen;
    fill_mag = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    fill_q   = '{32'd1, 32'd4, 32'd9, 32'd16, 32'd25};

    reset_n = 1'b0; in_x = '0; in_y = '0; in_valid = 1'b0; out_ready = 1'b0;
    hold_ready = 1'b0; stray_req = 1'b0; lat = 2;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_qvalid", {31'd0, sq_query_valid}, 32'd0);
    check("rst_query", sq_query, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_mag", {16'd0, out_mag}, 32'd0);
`ifdef ANFSQRT_MAG_SAT_FLAG_EN
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    push(16'd3, 16'd4);
    wait_out("p34", 16'd5, 32'd25, 1'b0);
    check("p34_single_pulse", 32'(dbl_pulse), 32'd0);

    lat = 0;
    push(16'd0, 16'd0);
    wait_out("p00", 16'd0, 32'd0, 1'b0);

    lat = 3;
    push(16'hFFFF, 16'hFFFF);
    wait_out("pmax", 16'hFFFF, 32'hFFFF_FFFF, 1'b1);

    hold_ready = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= DEPTH; i++) push(16'(i), 16'd0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    pc = pulse_cnt;
    in_x = 16'd9; in_y = 16'd0; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("full_still_blocked", {31'd0, in_ready}, 32'd0);
    check("full_no_issue", 32'(pulse_cnt), 32'(pc));
    hold_ready = 1'b0;
    push(16'd5, 16'd0);
    for (int i = 0; i < 5; i++) wait_out($sformatf("fill%0d", i + 1), fill_mag[i], fill_q[i], 1'b0);

    lat = 1;
    push(16'd6, 16'd8);
    push(16'd5, 16'd12);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_query", last_q, 32'd100);
    pc = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_mag%0d", i), {out_valid, 15'd0, out_mag}, {1'b1, 15'd0, 16'd10});
    end
    check("stall_no_issue", 32'(pulse_cnt), 32'(pc));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_out("p512", 16'd13, 32'd169, 1'b0);

    lat = 20;
    pc = pulse_cnt;
    push(16'd1, 16'd0);
    push(16'd2, 16'd0);
    push(16'd3, 16'd0);
    t = 0;
    while (pulse_cnt == pc && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_issued", 32'(pulse_cnt), 32'(pc + 1));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_query", sq_query, 32'd0);
    check("mid_rst_qvalid", {31'd0, sq_query_valid}, 32'd0);
    check("mid_rst_out_mag", {16'd0, out_mag}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pc = pulse_cnt;
    stray_req = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("stray_ignored", {31'd0, seen}, 32'd0);
    check("queue_flushed", 32'(pulse_cnt), 32'(pc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
